demux_dispatcher: RTL and testbench
===================================

# demux_dispatcher

Stream dispatcher that steers a single valid/ready input stream to one of 2^ADDRESS_WIDTH consumers. It sits in front of the plumbing demultiplexor and supplies its address and enable. It owns a one-entry output register, selects the target either round-robin or from a per-beat destination field, and holds each beat until the selected consumer accepts it.

## Interface
- ADDRESS_WIDTH, 2, consumer select width; N = 1<<ADDRESS_WIDTH consumers
- DATA_WIDTH, 8, payload width
- i_clk  in  1  sole clock, rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_flush  in  1  synchronous clear of held beat and round-robin pointer
- i_mode  in  1  0 = round-robin target, 1 = directed target (i_dest)
- i_valid  in  1  input beat valid
- o_ready  out  1  dispatcher can accept input beat
- i_data  in  DATA_WIDTH  input payload
- i_dest  in  ADDRESS_WIDTH  target consumer, used only when i_mode=1
- o_valid  out  N  one-hot valid; bit k set only while holding a beat for consumer k
- i_ready  in  N  per-consumer ready
- o_data  out  DATA_WIDTH  held payload, shared by all consumers
- o_address  out  ADDRESS_WIDTH  target of held beat
- o_rr_ptr  out  ADDRESS_WIDTH  next round-robin target

## Operation
- State: full flag (EMPTY/FULL), data register, address register, rr pointer.
- Accept = i_valid & o_ready & ~i_flush. Deliver = full & i_ready[o_address].
- o_ready = ~i_flush & (~full | i_ready[o_address]), combinational.
- On accept: data <= i_data; address <= i_mode ? i_dest : rr_ptr; full <= 1.
- On deliver without accept: full <= 0. Deliver and accept in the same cycle: register reloads and full stays 1.
- rr_ptr increments modulo N on each accept with i_mode=0, wrapping N-1 -> 0. Directed accepts leave it unchanged.
- i_mode and i_dest are sampled only on the accept cycle. Changing them while FULL has no effect on the held beat.
- o_valid = full ? onehot(o_address) : 0. It is generated by the demultiplexor instance with i_x = full.
- o_valid, o_data and o_address are stable while FULL and the target is not ready. The held beat is never dropped except by flush or reset.
- i_flush has priority: full <= 0, rr_ptr <= 0, o_ready = 0 that cycle. The data and address registers are not cleared.
- Ready on non-selected consumers is ignored.

## Timing
- Reset values: o_valid = 0, o_data = 0, o_address = 0, o_rr_ptr = 0, full = 0. o_ready = 1 after reset deassert unless i_flush is high.
- Reset assertion mid-transfer clears state immediately; the held beat is lost.
- Latency: accept in cycle t gives o_valid in cycle t+1.
- Throughput: 1 beat/cycle while targets are ready. A stalled target blocks all traffic (head-of-line).
- No combinational path from i_valid or i_data to any output. o_ready depends combinationally on i_ready and i_flush only.

## Structure
- Shared package: mode constants MODE_RR = 1'b0 and MODE_DIRECTED = 1'b1.
- The sub-module is the existing demultiplexor, instantiated with ADDRESS_WIDTH passed through and driving o_valid.
- Registers and the pointer live in this module, one always block per register group.

## Test plan
- Reset, then 8 back-to-back RR beats 0x10..0x17 with all i_ready=1 (N=4) -> delivered to consumers 0,1,2,3,0,1,2,3, one per cycle; o_rr_ptr ends at 0.
- Directed beats with i_dest=2, 2, 0 -> o_valid=4'b0100, 4'b0100, 4'b0001; o_rr_ptr unchanged at its prior value.
- Beat 0xA5 to consumer 1 with i_ready[1]=0 for 5 cycles and other readies 1 -> o_valid=4'b0010 and o_data=0xA5 held, o_ready=0 throughout; delivery on cycle 6.
- Simultaneous deliver and accept: held beat to consumer 3 with i_ready[3]=1, new beat 0x3C on i_valid -> next cycle o_data=0x3C with no bubble.
- i_flush while FULL with rr_ptr=2 -> next cycle o_valid=0, o_rr_ptr=0, and the beat presented during flush is not accepted.
- Assert i_rst_n=0 mid-stall, asynchronously between clock edges -> o_valid=0 and o_data=0 immediately.

Source files
------------

// File: rtl/demux_dispatcher_pkg.sv
// Shared constants for the stream dispatcher: target-select modes and holding-register states.
package demux_dispatcher_pkg;

  localparam logic MODE_RR       = 1'b0;
  localparam logic MODE_DIRECTED = 1'b1;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

endpackage

// File: rtl/demux_dispatcher_demux.sv
// Plumbing demultiplexor: routes the single enable i_x onto bit i_address of a one-hot output.
// Purely combinational, no latency; it carries no flow control of its own.
module demux_dispatcher_demux #(
  parameter int ADDRESS_WIDTH = 2
) (
  input  logic                            i_x,
  input  logic [ADDRESS_WIDTH-1:0]        i_address,
  output logic [(1<<ADDRESS_WIDTH)-1:0]   o_y
);

  always_comb begin
    o_y            = '0;
    o_y[i_address] = i_x;
  end

endmodule

// File: rtl/demux_dispatcher.sv
// One-entry dispatcher: steers a valid/ready stream to one of N consumers, round-robin or directed.
// Accept-to-valid latency of 1 cycle; the held beat stalls the input until its target is ready.
module demux_dispatcher
  import demux_dispatcher_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_flush,
  input  logic                          i_mode,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic [ADDRESS_WIDTH-1:0]      i_dest,
  output logic [(1<<ADDRESS_WIDTH)-1:0] o_valid,
  input  logic [(1<<ADDRESS_WIDTH)-1:0] i_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [ADDRESS_WIDTH-1:0]      o_address,
  output logic [ADDRESS_WIDTH-1:0]      o_rr_ptr
);

  logic                     full_q, full_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic sel_rdy;
  logic accept;
  logic deliver;

  // Readiness of non-selected consumers never reaches the handshake.
  assign sel_rdy = i_ready[addr_q];
  assign o_ready = ~i_flush & ((full_q == ST_EMPTY) | sel_rdy);
  assign accept  = i_valid & o_ready;
  assign deliver = (full_q == ST_FULL) & sel_rdy;

  always_comb begin
    full_d = full_q;
    if (i_flush) begin
      full_d = ST_EMPTY;
    end else if (accept) begin
      full_d = ST_FULL;
    end else if (deliver) begin
      full_d = ST_EMPTY;
    end
  end

  // Mode and destination only matter on the accept cycle; later changes cannot disturb the held beat.
  always_comb begin
    data_d = data_q;
    addr_d = addr_q;
    if (accept) begin
      data_d = i_data;
      addr_d = (i_mode == MODE_DIRECTED) ? i_dest : rr_ptr_q;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (i_flush) begin
      rr_ptr_d = '0;
    end else if (accept && (i_mode == MODE_RR)) begin
      rr_ptr_d = rr_ptr_q + ADDRESS_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q <= ST_EMPTY;
    end else begin
      full_q <= full_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
      addr_q <= '0;
    end else begin
      data_q <= data_d;
      addr_q <= addr_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  demux_dispatcher_demux #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_demux (
    .i_x       (full_q),
    .i_address (addr_q),
    .o_y       (o_valid)
  );

  assign o_data    = data_q;
  assign o_address = addr_q;
  assign o_rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed bench for demux_dispatcher (N=4, 8-bit data); inputs change 1 unit after posedge, outputs checked on negedge.
module tb_demux_dispatcher;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       mode;
  logic       in_vld;
  logic       out_rdy;
  logic [7:0] in_dat;
  logic [1:0] dest;
  logic [3:0] out_vld;
  logic [3:0] cons_rdy;
  logic [7:0] out_dat;
  logic [1:0] out_addr;
  logic [1:0] rr_ptr;

  int vecs = 0;
  int errs = 0;

  demux_dispatcher #(
    .ADDRESS_WIDTH (2),
    .DATA_WIDTH    (8)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_flush   (flush),
    .i_mode    (mode),
    .i_valid   (in_vld),
    .o_ready   (out_rdy),
    .i_data    (in_dat),
    .i_dest    (dest),
    .o_valid   (out_vld),
    .i_ready   (cons_rdy),
    .o_data    (out_dat),
    .o_address (out_addr),
    .o_rr_ptr  (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    flush    = 1'b0;
    mode     = 1'b0;
    in_vld   = 1'b0;
    in_dat   = 8'h00;
    dest     = 2'd0;
    cons_rdy = 4'b1111;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    vecs++; if (out_vld !== 4'b0000) begin errs++; $display("FAIL reset_valid got %b want 0000", out_vld); end
    vecs++; if (out_dat !== 8'h00) begin errs++; $display("FAIL reset_data got %h want 00", out_dat); end
    vecs++; if (out_addr !== 2'd0) begin errs++; $display("FAIL reset_addr got %0d want 0", out_addr); end
    vecs++; if (rr_ptr !== 2'd0) begin errs++; $display("FAIL reset_rr got %0d want 0", rr_ptr); end
    vecs++; if (out_rdy !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", out_rdy); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_v;
    mode     = 1'b0;
    cons_rdy = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      in_vld = 1'b1;
      in_dat = 8'h10 + 8'(k);
      @(negedge clk);
      vecs++; if (out_rdy !== 1'b1) begin errs++; $display("FAIL rr_ready beat %0d got %b want 1", k, out_rdy); end
      if (k > 0) begin
        exp_v = 4'b0001 << ((k - 1) % 4);
        vecs++; if (out_vld !== exp_v) begin errs++; $display("FAIL rr_valid beat %0d got %b want %b", k - 1, out_vld, exp_v); end
        vecs++; if (out_dat !== 8'h10 + 8'(k - 1)) begin errs++; $display("FAIL rr_data beat %0d got %h want %h", k - 1, out_dat, 8'h10 + 8'(k - 1)); end
        vecs++; if (rr_ptr !== 2'(k % 4)) begin errs++; $display("FAIL rr_ptr beat %0d got %0d want %0d", k - 1, rr_ptr, k % 4); end
      end
      next_cycle();
    end
    in_vld = 1'b0;
    @(negedge clk);
    vecs++; if (out_vld !== 4'b1000) begin errs++; $display("FAIL rr_valid beat 7 got %b want 1000", out_vld); end
    vecs++; if (out_dat !== 8'h17) begin errs++; $display("FAIL rr_data beat 7 got %h want 17", out_dat); end
    next_cycle();
    @(negedge clk);
    vecs++; if (out_vld !== 4'b0000) begin errs++; $display("FAIL rr_drain got %b want 0000", out_vld); end
    vecs++; if (rr_ptr !== 2'd0) begin errs++; $display("FAIL rr_ptr_end got %0d want 0", rr_ptr); end
    next_cycle();
  endtask

  task automatic test_directed();
    logic       modes [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] dests [4] = '{2'd3, 2'd2, 2'd2, 2'd0};
    logic [3:0] exps  [4] = '{4'b0001, 4'b0100, 4'b0100, 4'b0001};
    cons_rdy = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      in_vld = 1'b1;
      mode   = modes[k];
      dest   = dests[k];
      in_dat = 8'h20 + 8'(k);
      @(negedge clk);
      if (k > 0) begin
        vecs++; if (out_vld !== exps[k-1]) begin errs++; $display("FAIL dir_valid beat %0d got %b want %b", k - 1, out_vld, exps[k-1]); end
        vecs++; if (rr_ptr !== 2'd1) begin errs++; $display("FAIL dir_rr beat %0d got %0d want 1", k - 1, rr_ptr); end
      end
      next_cycle();
    end
    in_vld = 1'b0;
    mode   = 1'b0;
    @(negedge clk);
    vecs++; if (out_vld !== exps[3]) begin errs++; $display("FAIL dir_valid beat 3 got %b want %b", out_vld, exps[3]); end
    vecs++; if (out_dat !== 8'h23) begin errs++; $display("FAIL dir_data beat 3 got %h want 23", out_dat); end
    vecs++; if (rr_ptr !== 2'd1) begin errs++; $display("FAIL dir_rr_end got %0d want 1", rr_ptr); end
    next_cycle();
  endtask

  task automatic test_stall();
    cons_rdy = 4'b1101;
    mode     = 1'b0;
    in_vld   = 1'b1;
    in_dat   = 8'hA5;
    next_cycle();
    // A competing beat with a different mode/dest must neither enter nor disturb the held one.
    in_dat = 8'h5A;
    mode   = 1'b1;
    dest   = 2'd3;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      vecs++; if (out_vld !== 4'b0010) begin errs++; $display("FAIL stall_valid cyc %0d got %b want 0010", s, out_vld); end
      vecs++; if (out_dat !== 8'hA5) begin errs++; $display("FAIL stall_data cyc %0d got %h want a5", s, out_dat); end
      vecs++; if (out_rdy !== 1'b0) begin errs++; $display("FAIL stall_ready cyc %0d got %b want 0", s, out_rdy); end
      vecs++; if (out_addr !== 2'd1) begin errs++; $display("FAIL stall_addr cyc %0d got %0d want 1", s, out_addr); end
      next_cycle();
    end
    in_vld   = 1'b0;
    mode     = 1'b0;
    cons_rdy = 4'b1111;
    @(negedge clk);
    vecs++; if (out_rdy !== 1'b1) begin errs++; $display("FAIL stall_release_ready got %b want 1", out_rdy); end
    vecs++; if (out_vld !== 4'b0010) begin errs++; $display("FAIL stall_release_valid got %b want 0010", out_vld); end
    next_cycle();
    @(negedge clk);
    vecs++; if (out_vld !== 4'b0000) begin errs++; $display("FAIL stall_delivered got %b want 0000", out_vld); end
    vecs++; if (rr_ptr !== 2'd2) begin errs++; $display("FAIL stall_rr got %0d want 2", rr_ptr); end
    next_cycle();
  endtask

  task automatic test_flush();
    cons_rdy = 4'b0111;
    mode     = 1'b1;
    dest     = 2'd3;
    in_vld   = 1'b1;
    in_dat   = 8'h66;
    next_cycle();
    flush  = 1'b1;
    mode   = 1'b0;
    in_dat = 8'h99;
    @(negedge clk);
    vecs++; if (out_vld !== 4'b1000) begin errs++; $display("FAIL flush_pre_valid got %b want 1000", out_vld); end
    vecs++; if (rr_ptr !== 2'd2) begin errs++; $display("FAIL flush_pre_rr got %0d want 2", rr_ptr); end
    vecs++; if (out_rdy !== 1'b0) begin errs++; $display("FAIL flush_ready got %b want 0", out_rdy); end
    next_cycle();
    flush  = 1'b0;
    in_vld = 1'b0;
    @(negedge clk);
    vecs++; if (out_vld !== 4'b0000) begin errs++; $display("FAIL flush_valid got %b want 0000", out_vld); end
    vecs++; if (rr_ptr !== 2'd0) begin errs++; $display("FAIL flush_rr got %0d want 0", rr_ptr); end
    vecs++; if (out_dat !== 8'h66) begin errs++; $display("FAIL flush_data_kept got %h want 66", out_dat); end
    vecs++; if (out_addr !== 2'd3) begin errs++; $display("FAIL flush_addr_kept got %0d want 3", out_addr); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    cons_rdy = 4'b0111;
    mode     = 1'b1;
    dest     = 2'd3;
    in_vld   = 1'b1;
    in_dat   = 8'hC3;
    next_cycle();
    cons_rdy = 4'b1111;
    mode     = 1'b0;
    in_dat   = 8'h3C;
    @(negedge clk);
    vecs++; if (out_vld !== 4'b1000) begin errs++; $display("FAIL b2b_held_valid got %b want 1000", out_vld); end
    vecs++; if (out_rdy !== 1'b1) begin errs++; $display("FAIL b2b_ready got %b want 1", out_rdy); end
    next_cycle();
    in_vld = 1'b0;
    @(negedge clk);
    vecs++; if (out_dat !== 8'h3C) begin errs++; $display("FAIL b2b_data got %h want 3c", out_dat); end
    vecs++; if (out_vld !== 4'b0001) begin errs++; $display("FAIL b2b_valid got %b want 0001", out_vld); end
    vecs++; if (rr_ptr !== 2'd1) begin errs++; $display("FAIL b2b_rr got %0d want 1", rr_ptr); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    cons_rdy = 4'b1101;
    mode     = 1'b0;
    in_vld   = 1'b1;
    in_dat   = 8'h77;
    next_cycle();
    in_vld = 1'b0;
    @(negedge clk);
    vecs++; if (out_vld !== 4'b0010) begin errs++; $display("FAIL arst_pre_valid got %b want 0010", out_vld); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (out_vld !== 4'b0000) begin errs++; $display("FAIL arst_valid got %b want 0000", out_vld); end
    vecs++; if (out_dat !== 8'h00) begin errs++; $display("FAIL arst_data got %h want 00", out_dat); end
    vecs++; if (rr_ptr !== 2'd0) begin errs++; $display("FAIL arst_rr got %0d want 0", rr_ptr); end
    next_cycle();
    rst_n    = 1'b1;
    cons_rdy = 4'b1111;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_directed();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
